hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
Central stall/flush scheduler for the 5-stage pipeline. Drives PC write-enable, the IF/ID register's IF_Stall/IF_Flush, the ID/EX bubble insert and next-PC select. Arbitrates between competing events: load-use hazards, EX-resolved branches, ID jumps, multi-cycle mul/div occupancy and an external interrupt. Tracks mul/div busy and interrupt-in-service state, and keeps a stall-cycle performance counter.

Parameters:
MD_LAT, 4, mul/div latency in cycles (>=2); the busy window lasts MD_LAT-1 cycles after the start cycle.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_UsesRt  in  1  instruction in ID reads rt
ID_Jump  in  1  instruction in ID is j/jal/jr/jalr
ID_MdUse  in  1  instruction in ID is mfhi/mflo/mult/div
ID_Eret  in  1  instruction in ID is eret
EX_MemRead  in  1  instruction in EX is a load
EX_rt  in  5  load destination in EX
EX_BranchTaken  in  1  branch resolved taken in EX
EX_MdStart  in  1  mul/div issued in EX this cycle
irq_req  in  1  interrupt request, level
PC_Write  out  1  PC register enable
IF_Stall  out  1  hold the IF/ID register
IF_Flush  out  1  zero the IF/ID instruction fields
ID_Flush  out  1  insert a bubble into ID/EX
PC_Sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = interrupt vector
EPC_Write  out  1  capture the ID-stage PC into EPC
irq_ack  out  1  one-cycle acknowledge, registered
md_busy  out  1  mul/div unit occupied, registered
stall_cnt  out  CNT_W  saturating count of cycles with PC_Write=0

Behaviour:
- Reset values: md_busy=0, irq_ack=0, stall_cnt=0, in-service flag=0, state=RUN. Combinational outputs at reset: PC_Write=1, IF_Stall=0, IF_Flush=0, ID_Flush=0, PC_Sel=0, EPC_Write=0.
- Reset mid-operation aborts the busy window and clears in-service immediately (asynchronous).
- States: RUN, MD_WAIT, IRQ_ACK. The md counter runs independently of the FSM's IRQ handling.
- Event conditions, evaluated each cycle:
  - lu = EX_MemRead & EX_rt!=0 & (EX_rt==ID_rs | (ID_UsesRt & EX_rt==ID_rt)).
  - mds = md_busy & ID_MdUse.
  - irq_ok = irq_req & ~in_service & state==RUN & ~md_busy.
- Priority, highest first; exactly one action per cycle:
  1. EX_BranchTaken: PC_Sel=1, IF_Flush=1, ID_Flush=1, PC_Write=1. Overrides lu, mds, jump and irq; an irq is deferred, not lost.
  2. irq_ok (and no lu): PC_Sel=3, EPC_Write=1, IF_Flush=1, ID_Flush=1, PC_Write=1; set in_service; next state IRQ_ACK.
  3. lu or mds: PC_Write=0, IF_Stall=1, ID_Flush=1, PC_Sel=0. A jump in ID waits; it is re-evaluated next cycle.
  4. ID_Jump: PC_Sel=2, IF_Flush=1, PC_Write=1.
  5. Otherwise: PC_Sel=0, PC_Write=1, all flush/stall outputs 0.
- IF_Flush and IF_Stall are never both 1.
- IRQ_ACK: irq_ack=1 for exactly one cycle, then RUN. Pipeline controls in this cycle follow rules 1 and 3-5; irq is blocked by in_service.
- ID_Eret while not stalled and not flushed clears in_service next edge.
- Mul/div:
  - EX_MdStart loads the counter with MD_LAT-1 and sets md_busy; state goes to MD_WAIT (unless already IRQ_ACK, which completes first).
  - The counter decrements every cycle, including stall and flush cycles. md_busy clears on the edge where the counter reaches 0.
  - EX_MdStart while busy reloads the counter.
  - An EX branch flush never cancels the busy window.
- stall_cnt increments on each edge with PC_Write=0 and saturates at all-ones (no wrap).

Test Plan:
- lw $5 in EX (EX_MemRead=1, EX_rt=5), ID_rs=5 -> exactly 1 cycle of PC_Write=0, IF_Stall=1, ID_Flush=1; stall_cnt 0->1. Repeat with EX_rt=0 -> no stall.
- EX_BranchTaken=1 with lu true, ID_Jump=1 and irq_req=1 in the same cycle -> PC_Sel=1, IF_Flush=1, ID_Flush=1, EPC_Write=0; irq taken the next cycle (PC_Sel=3, EPC_Write=1), irq_ack=1 the cycle after.
- MD_LAT=4: EX_MdStart pulse, then ID_MdUse=1 held -> md_busy high for 3 cycles, 3 stall cycles, PC_Write=1 on cycle 4; irq_req held throughout is accepted only after md_busy falls.
- irq accepted, irq_req kept high -> no second acceptance until ID_Eret is decoded; the next acceptance comes the cycle after in_service clears.
- Force stall_cnt to all-ones (CNT_W=4, 16 load-use stalls) -> holds at 15. Assert reset mid-MD_WAIT -> md_busy=0, stall_cnt=0, PC_Write=1 immediately, without a clock edge.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Stall/flush scheduler for the 5-stage pipeline: arbitrates load-use, branch, jump,
// mul/div occupancy and interrupt events into PC/IF/ID controls, plus a stall counter.
module hazard_sequencer #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             ID_MdUse,
  input  logic             ID_Eret,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rt,
  input  logic             EX_BranchTaken,
  input  logic             EX_MdStart,
  input  logic             irq_req,
  output logic             PC_Write,
  output logic             IF_Stall,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic [1:0]       PC_Sel,
  output logic             EPC_Write,
  output logic             irq_ack,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MdCntW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam logic [MdCntW-1:0] MdLoad = MdCntW'(MD_LAT - 1);

  typedef enum logic [1:0] {StRun, StMdWait, StIrqAck} state_e;

  state_e            state_q, state_d;
  logic [MdCntW-1:0] md_cnt_q, md_cnt_d;
  logic              md_busy_q, md_busy_d;
  logic              in_service_q, in_service_d;
  logic              irq_ack_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic lu, mds, irq_ok, take_irq;

  always_comb begin
    lu       = EX_MemRead & (EX_rt != 5'd0) &
               ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));
    mds      = md_busy_q & ID_MdUse;
    irq_ok   = irq_req & ~in_service_q & (state_q == StRun) & ~md_busy_q;
    // A taken branch defers the interrupt; a load-use hazard also holds it off.
    take_irq = ~EX_BranchTaken & irq_ok & ~lu;
  end

  // Pipeline controls; forced to their idle values while reset is asserted.
  always_comb begin
    PC_Write  = 1'b1;
    IF_Stall  = 1'b0;
    IF_Flush  = 1'b0;
    ID_Flush  = 1'b0;
    PC_Sel    = 2'd0;
    EPC_Write = 1'b0;
    if (!reset) begin
      if (EX_BranchTaken) begin
        PC_Sel   = 2'd1;
        IF_Flush = 1'b1;
        ID_Flush = 1'b1;
      end else if (take_irq) begin
        PC_Sel    = 2'd3;
        EPC_Write = 1'b1;
        IF_Flush  = 1'b1;
        ID_Flush  = 1'b1;
      end else if (lu | mds) begin
        PC_Write = 1'b0;
        IF_Stall = 1'b1;
        ID_Flush = 1'b1;
      end else if (ID_Jump) begin
        PC_Sel   = 2'd2;
        IF_Flush = 1'b1;
      end
    end
  end

  always_comb begin
    md_cnt_d  = md_cnt_q;
    md_busy_d = md_busy_q;
    if (EX_MdStart) begin
      md_cnt_d  = MdLoad;
      md_busy_d = 1'b1;
    end else if (md_busy_q) begin
      md_cnt_d  = md_cnt_q - MdCntW'(1);
      md_busy_d = (md_cnt_q != MdCntW'(1));
    end
  end

  always_comb begin
    in_service_d = in_service_q;
    if (take_irq) begin
      in_service_d = 1'b1;
    end else if (ID_Eret && !ID_Flush) begin
      // Only an eret that actually advances out of ID ends the handler.
      in_service_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (take_irq) begin
          state_d = StIrqAck;
        end else if (EX_MdStart) begin
          state_d = StMdWait;
        end
      end
      StMdWait: begin
        if (!md_busy_d) begin
          state_d = StRun;
        end
      end
      StIrqAck: state_d = md_busy_d ? StMdWait : StRun;
      default:  state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      md_cnt_q     <= '0;
      md_busy_q    <= 1'b0;
      in_service_q <= 1'b0;
      irq_ack_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      md_busy_q    <= md_busy_d;
      in_service_q <= in_service_d;
      irq_ack_q    <= take_irq;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign irq_ack   = irq_ack_q;
  assign md_busy   = md_busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule
